// File: rtl/lemming_world.sv
// -----------------------------------------------------------------------------
// lemming_world
//   Closed-loop environment for the lemming walker FSM. It tracks the lemming's
//   cell on a 1-D track of 2^XW cells with walls and holes, times each fall,
//   fills a hole once something has landed in it, counts landings and latches
//   a sticky splat flag when a fall lasts longer than FALL_LIMIT cycles.
//
// Ports
//   clk, areset_n           : clock, asynchronous active-low reset
//   walk_left/walk_right    : walker FSM Moore outputs (direction)
//   aaah                    : walker FSM Moore output (falling)
//   step_en                 : move permit for this cycle
//   wall_mask / hole_mask   : per-cell wall / hole bits (combinational effect)
//   hole_depth              : fall depth, sampled every non-falling cycle
//   ground, bump_left/right : to the walker FSM
//   x_pos, fall_cnt, splat, landings : observation / scoring outputs
// -----------------------------------------------------------------------------
module lemming_world #(
    parameter int XW         = 4,
    parameter int START_X    = 0,
    parameter int FALL_LIMIT = 20
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              walk_left,
    input  logic              walk_right,
    input  logic              aaah,
    input  logic              step_en,
    input  logic [2**XW-1:0]  wall_mask,
    input  logic [2**XW-1:0]  hole_mask,
    input  logic [7:0]        hole_depth,
    output logic              ground,
    output logic              bump_left,
    output logic              bump_right,
    output logic [XW-1:0]     x_pos,
    output logic [7:0]        fall_cnt,
    output logic              splat,
    output logic [7:0]        landings
);

    localparam int            N     = 2**XW;
    localparam logic [XW-1:0] MAX   = XW'(N - 1);
    localparam logic [XW-1:0] X0    = XW'(START_X);
    localparam logic [XW-1:0] ONE   = XW'(1);
    localparam logic [8:0]    LIMIT = 9'(FALL_LIMIT);

    logic [XW-1:0] x_pos_q,    x_pos_d;
    logic [7:0]    fall_cnt_q, fall_cnt_d;
    logic [7:0]    depth_q,    depth_d;
    logic [N-1:0]  filled_q,   filled_d;
    logic          aaah_q,     aaah_d;
    logic          splat_q,    splat_d;
    logic [7:0]    landings_q, landings_d;

    logic wall_l, wall_r, bl_raw, br_raw, hole_here, gnd_raw, landing;

    // Environment view before the splat override.
    always_comb begin
        wall_l    = (x_pos_q != '0)  ? wall_mask[x_pos_q - ONE] : 1'b0;
        wall_r    = (x_pos_q != MAX) ? wall_mask[x_pos_q + ONE] : 1'b0;
        bl_raw    = (x_pos_q == '0)  | wall_l;
        br_raw    = (x_pos_q == MAX) | wall_r;
        hole_here = hole_mask[x_pos_q] & ~filled_q[x_pos_q];
        // On the first falling cycle fall_cnt still holds the previous fall's
        // count and is about to restart at 1; the lemming cannot have reached
        // the bottom yet (depth_q >= 1), so ground stays low that cycle.
        if (aaah) gnd_raw = aaah_q & (fall_cnt_q >= depth_q);
        else      gnd_raw = ~hole_here;
        landing   = ~aaah & aaah_q;
    end

    // A dead lemming sees solid ground and no walls.
    assign ground     = splat_q | gnd_raw;
    assign bump_left  = ~splat_q & bl_raw;
    assign bump_right = ~splat_q & br_raw;

    always_comb begin
        x_pos_d    = x_pos_q;
        fall_cnt_d = fall_cnt_q;
        depth_d    = depth_q;
        filled_d   = filled_q;
        aaah_d     = aaah;
        splat_d    = splat_q;
        landings_d = landings_q;

        // Depth is tracked while walking and frozen for the whole fall.
        if (!aaah) depth_d = (hole_depth == 8'd0) ? 8'd1 : hole_depth;

        if (!splat_q) begin
            if (!aaah) begin
                if (step_en && walk_left && !walk_right && gnd_raw && !bl_raw)
                    x_pos_d = x_pos_q - ONE;
                else if (step_en && walk_right && !walk_left && gnd_raw && !br_raw)
                    x_pos_d = x_pos_q + ONE;
            end else if (!aaah_q) begin
                fall_cnt_d = 8'd1;
            end else if (fall_cnt_q < depth_q) begin
                // Count stops at the bottom; depth_q <= 255 keeps it saturated.
                fall_cnt_d = fall_cnt_q + 8'd1;
            end

            if (landing) begin
                landings_d = landings_q + 8'd1;
                if ({1'b0, fall_cnt_q} > LIMIT) splat_d = 1'b1;
            end
        end

        if (landing) filled_d[x_pos_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            x_pos_q    <= X0;
            fall_cnt_q <= 8'd0;
            depth_q    <= 8'd1;
            filled_q   <= '0;
            aaah_q     <= 1'b0;
            splat_q    <= 1'b0;
            landings_q <= 8'd0;
        end else begin
            x_pos_q    <= x_pos_d;
            fall_cnt_q <= fall_cnt_d;
            depth_q    <= depth_d;
            filled_q   <= filled_d;
            aaah_q     <= aaah_d;
            splat_q    <= splat_d;
            landings_q <= landings_d;
        end
    end

    assign x_pos    = x_pos_q;
    assign fall_cnt = fall_cnt_q;
    assign splat    = splat_q;
    assign landings = landings_q;

endmodule

// File: tb/tb_lemming_world.sv
module tb_lemming_world;

    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic        walk_left = 1'b0, walk_right = 1'b0, aaah = 1'b0, step_en = 1'b0;
    logic [15:0] wall_mask = '0, hole_mask = '0;
    logic [7:0]  hole_depth = 8'd0;
    logic        ground, bump_left, bump_right, splat;
    logic [3:0]  x_pos;
    logic [7:0]  fall_cnt, landings;

    int n_cmp = 0;
    int n_bad = 0;
    int nf;

    lemming_world #(.XW(4), .START_X(0), .FALL_LIMIT(20)) dut (
        .clk(clk), .areset_n(areset_n),
        .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah), .step_en(step_en),
        .wall_mask(wall_mask), .hole_mask(hole_mask), .hole_depth(hole_depth),
        .ground(ground), .bump_left(bump_left), .bump_right(bump_right),
        .x_pos(x_pos), .fall_cnt(fall_cnt), .splat(splat), .landings(landings)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic wl, input logic wr, input logic se);
        walk_left = wl; walk_right = wr; step_en = se; aaah = 1'b0;
        tick();
    endtask

    // Acts like the walker in FALL: aaah held until ground, then one landing
    // cycle. Walk/step inputs are driven during the fall to show they are ignored.
    task automatic do_fall(output int n);
        bit g;
        n = 0; g = 1'b0;
        aaah = 1'b1; walk_left = 1'b0; walk_right = 1'b1; step_en = 1'b1;
        while (!g && n < 300) begin
            #1;
            g = ground;
            n++;
            tick();
        end
        if (!g) chk("fall_timeout", 32'(g), 1);
        aaah = 1'b0; walk_right = 1'b0; step_en = 1'b0;
        tick();
    endtask

    initial begin
        // ---- reset state
        #3;
        chk("rst_x", x_pos, 0);
        chk("rst_fall_cnt", fall_cnt, 0);
        chk("rst_splat", splat, 0);
        chk("rst_landings", landings, 0);
        chk("rst_bump_left", bump_left, 1);
        chk("rst_bump_right", bump_right, 0);
        chk("rst_ground", ground, 1);
        #9 areset_n = 1'b1;
        tick();

        // ---- open track, bounce off both ends
        step(1, 0, 1); chk("edge_left_block", x_pos, 0);
        step(0, 1, 0); chk("step_en_off", x_pos, 0);
        step(1, 1, 1); chk("both_dirs", x_pos, 0);
        for (int i = 1; i <= 15; i++) begin
            step(0, 1, 1); chk("walk_right_x", x_pos, i);
        end
        chk("bump_right_max", bump_right, 1);
        step(0, 1, 1); chk("edge_right_block", x_pos, 15);
        for (int i = 14; i >= 0; i--) begin
            step(1, 0, 1); chk("walk_left_x", x_pos, i);
        end
        chk("bump_left_zero", bump_left, 1);
        chk("open_no_splat", splat, 0);

        // ---- wall at cell 5
        wall_mask = 16'h0020;
        for (int i = 1; i <= 4; i++) step(0, 1, 1);
        chk("wall_stop_x", x_pos, 4);
        chk("wall_bump_right", bump_right, 1);
        step(0, 1, 1); chk("wall_blocked", x_pos, 4);
        step(1, 0, 1); chk("wall_reverse", x_pos, 3);
        wall_mask = '0;

        // ---- hole at cell 6, depth 3
        hole_mask = 16'h0040; hole_depth = 8'd3;
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
        chk("hole_x", x_pos, 6);
        chk("hole_ground", ground, 0);
        do_fall(nf);
        chk("d3_aaah_cycles", nf, 4);
        chk("d3_fall_cnt", fall_cnt, 3);
        chk("d3_landings", landings, 1);
        chk("d3_splat", splat, 0);
        chk("d3_x_frozen", x_pos, 6);
        chk("d3_filled_ground", ground, 1);
        step(0, 1, 1); step(1, 0, 1);
        chk("repass_x", x_pos, 6);
        chk("repass_ground", ground, 1);

        // ---- hole at cell 10, depth 25 -> splat
        hole_mask = 16'h0440; hole_depth = 8'd25;
        for (int i = 0; i < 4; i++) step(0, 1, 1);
        chk("deep_x", x_pos, 10);
        do_fall(nf);
        chk("d25_aaah_cycles", nf, 26);
        chk("d25_fall_cnt", fall_cnt, 25);
        chk("d25_splat", splat, 1);
        chk("d25_landings", landings, 2);
        wall_mask = 16'hFFFF;
        #1;
        chk("splat_ground", ground, 1);
        chk("splat_bump_left", bump_left, 0);
        chk("splat_bump_right", bump_right, 0);
        step(1, 0, 1); step(0, 1, 1);
        chk("splat_x_frozen", x_pos, 10);
        aaah = 1'b1; tick(); tick(); tick();
        aaah = 1'b0; tick();
        chk("splat_landings_frozen", landings, 2);
        chk("splat_fall_cnt_frozen", fall_cnt, 25);
        wall_mask = '0;

        // ---- reset, then depth-0 hole at cell 1
        areset_n = 1'b0; #1;
        chk("rst2_x", x_pos, 0);
        chk("rst2_splat", splat, 0);
        chk("rst2_landings", landings, 0);
        #1 areset_n = 1'b1;
        hole_mask = 16'h0002; hole_depth = 8'd0;
        tick();
        step(0, 1, 1);
        chk("d0_x", x_pos, 1);
        chk("d0_ground", ground, 0);
        do_fall(nf);
        chk("d0_aaah_cycles", nf, 2);
        chk("d0_fall_cnt", fall_cnt, 1);
        chk("d0_landings", landings, 1);

        // ---- reset in the middle of a fall at cell 3
        hole_mask = 16'h000A; hole_depth = 8'd20;
        step(0, 1, 1); step(0, 1, 1);
        chk("mid_x", x_pos, 3);
        aaah = 1'b1; walk_right = 1'b0; step_en = 1'b0;
        repeat (7) tick();
        chk("mid_fall_cnt7", fall_cnt, 7);
        areset_n = 1'b0; #1;
        chk("mid_rst_x", x_pos, 0);
        chk("mid_rst_fall_cnt", fall_cnt, 0);
        chk("mid_rst_landings", landings, 0);
        chk("mid_rst_splat", splat, 0);
        aaah = 1'b0;
        #1 areset_n = 1'b1;
        tick();
        chk("mid_no_landing", landings, 0);
        step(0, 1, 1);
        chk("unfilled_x", x_pos, 1);
        chk("unfilled_ground", ground, 0);

        // ---- FALL_LIMIT boundary: 20 survives, 21 splats
        do_fall(nf);
        chk("d20_aaah_cycles", nf, 21);
        chk("d20_fall_cnt", fall_cnt, 20);
        chk("d20_splat", splat, 0);
        chk("d20_landings", landings, 1);
        hole_depth = 8'd21;
        step(0, 1, 1); step(0, 1, 1);
        chk("d21_x", x_pos, 3);
        do_fall(nf);
        chk("d21_aaah_cycles", nf, 22);
        chk("d21_fall_cnt", fall_cnt, 21);
        chk("d21_splat", splat, 1);
        chk("d21_landings", landings, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
